// File: rtl/synaptic_frame_feeder_if.sv
// Frame/SIP bus for synaptic_frame_feeder: upstream spike-frame handshake plus the SIP-facing frame outputs.
// Upstream handshake: a frame transfers at a rising edge where frame_valid && frame_ready; SIP side: write is a level held until flush_weight is sampled high.
interface synaptic_frame_feeder_if #(
  parameter int NUM_SYN = 16,
  parameter int W_BITS  = 4
);
  logic                      frame_valid;
  logic [NUM_SYN-1:0]        frame_data;
  logic                      frame_ready;
  logic [NUM_SYN-1:0]        parallel_spike_in;
  logic [NUM_SYN-1:0]        parallel_Ein;
  logic [NUM_SYN*W_BITS-1:0] parallel_weight;
  logic                      write;
  logic                      flush_weight;

  modport master (
    output frame_valid, frame_data, flush_weight,
    input  frame_ready, parallel_spike_in, parallel_Ein, parallel_weight, write
  );

  modport slave (
    input  frame_valid, frame_data, flush_weight,
    output frame_ready, parallel_spike_in, parallel_Ein, parallel_weight, write
  );
endinterface

// File: rtl/synaptic_frame_feeder.sv
// Spike-frame FIFO + weight/Ein shadow bank feeding one SIP, one frame at a time.
// Optional macro SKIP_EMPTY_FRAME_EN: all-zero head frames are discarded instead of presented.
module synaptic_frame_feeder #(
  parameter int               NUM_SYN    = 16,
  parameter int               W_BITS     = 4,
  parameter int               FIFO_DEPTH = 4,
  parameter logic [NUM_SYN-1:0] EIN_RESET = 16'hFFFF
) (
  input  logic                  clock,
  input  logic                  reset,
  synaptic_frame_feeder_if.slave sip,
  input  logic                  cfg_w_we,
  input  logic [3:0]            cfg_w_addr,
  input  logic [W_BITS-1:0]     cfg_w_data,
  input  logic                  cfg_ein_we,
  input  logic [NUM_SYN-1:0]    cfg_ein,
  output logic                  busy,
  output logic [7:0]            frame_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [NUM_SYN-1:0]        mem_q [FIFO_DEPTH];
  logic [NUM_SYN-1:0]        mem_d [FIFO_DEPTH];
  logic [PW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             count_q, count_d;
  logic [NUM_SYN-1:0]        spike_q, spike_d, ein_q, ein_d, ein_sh_q, ein_sh_d;
  logic [NUM_SYN*W_BITS-1:0] weight_q, weight_d, w_sh_q, w_sh_d;
  logic                      write_q, write_d;
  logic [7:0]                fc_q, fc_d;
  logic                      push, pop, load;
  logic [NUM_SYN-1:0]        head;

  assign sip.frame_ready       = (count_q != CW'(FIFO_DEPTH));
  assign sip.parallel_spike_in = spike_q;
  assign sip.parallel_Ein      = ein_q;
  assign sip.parallel_weight   = weight_q;
  assign sip.write             = write_q;
  assign busy                  = (state_q == ACTIVE);
  assign frame_count           = fc_q;
  assign head                  = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    spike_d  = spike_q;
    ein_d    = ein_q;
    weight_d = weight_q;
    write_d  = write_q;
    fc_d     = fc_q;
    ein_sh_d = ein_sh_q;
    w_sh_d   = w_sh_q;
    push     = sip.frame_valid && sip.frame_ready;
    pop      = 1'b0;
    load     = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop = 1'b1;
`ifdef SKIP_EMPTY_FRAME_EN
          load = (head != '0);
`else
          load = 1'b1;
`endif
        end
      end
      ACTIVE: begin
        if (sip.flush_weight) begin
          write_d = 1'b0;
          fc_d    = fc_q + 8'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Load uses the shadow values as they stood before this edge's cfg writes.
    if (load) begin
      spike_d  = head;
      ein_d    = ein_sh_q;
      weight_d = w_sh_q;
      write_d  = 1'b1;
      state_d  = ACTIVE;
    end

    if (cfg_w_we)   w_sh_d[int'(cfg_w_addr)*W_BITS +: W_BITS] = cfg_w_data;
    if (cfg_ein_we) ein_sh_d = cfg_ein;

    if (push) begin
      mem_d[wr_ptr_q] = sip.frame_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      spike_q  <= '0;
      ein_q    <= EIN_RESET;
      weight_q <= '0;
      write_q  <= 1'b0;
      fc_q     <= '0;
      ein_sh_q <= EIN_RESET;
      w_sh_q   <= '0;
    end else begin
      state_q  <= state_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      spike_q  <= spike_d;
      ein_q    <= ein_d;
      weight_q <= weight_d;
      write_q  <= write_d;
      fc_q     <= fc_d;
      ein_sh_q <= ein_sh_d;
      w_sh_q   <= w_sh_d;
    end
  end
endmodule

// File: tb/tb_synaptic_frame_feeder.sv
// Self-checking bench for synaptic_frame_feeder against a queue-based frame model.
// Honours SKIP_EMPTY_FRAME_EN when the same macro is defined for the bench.
module tb_synaptic_frame_feeder;
`ifdef SKIP_EMPTY_FRAME_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_w_we = 1'b0;
  logic [3:0]  cfg_w_addr = '0;
  logic [3:0]  cfg_w_data = '0;
  logic        cfg_ein_we = 1'b0;
  logic [15:0] cfg_ein = '0;
  logic        busy;
  logic [7:0]  frame_count;

  int tests = 0;
  int fails = 0;

  synaptic_frame_feeder_if #(.NUM_SYN(16), .W_BITS(4)) ifc ();

  synaptic_frame_feeder dut (
    .clock       (clock),
    .reset       (reset),
    .sip         (ifc.slave),
    .cfg_w_we    (cfg_w_we),
    .cfg_w_addr  (cfg_w_addr),
    .cfg_w_data  (cfg_w_data),
    .cfg_ein_we  (cfg_ein_we),
    .cfg_ein     (cfg_ein),
    .busy        (busy),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  // Reference model: frame queue, presented slot, shadow bank.
  logic [15:0] fifo_m[$];
  bit          act_m;
  logic [15:0] spike_m, ein_m, ein_sh_m;
  logic [63:0] weight_m;
  logic [3:0]  w_sh_m [16];
  logic [7:0]  fc_m;

  function automatic void model_reset();
    fifo_m.delete();
    act_m    = 1'b0;
    spike_m  = '0;
    ein_m    = 16'hFFFF;
    ein_sh_m = 16'hFFFF;
    weight_m = '0;
    fc_m     = '0;
    for (int i = 0; i < 16; i++) w_sh_m[i] = '0;
  endfunction

  function automatic logic [106:0] exp_vec();
    return {act_m, fifo_m.size() < 4, act_m, fc_m, spike_m, ein_m, weight_m};
  endfunction

  function automatic logic [106:0] act_vec();
    return {ifc.write, ifc.frame_ready, busy, frame_count,
            ifc.parallel_spike_in, ifc.parallel_Ein, ifc.parallel_weight};
  endfunction

  task automatic clear_inputs();
    ifc.frame_valid  = 1'b0;
    ifc.frame_data   = '0;
    ifc.flush_weight = 1'b0;
    cfg_w_we   = 1'b0;
    cfg_ein_we = 1'b0;
  endtask

  // Advance the model by one edge using the inputs now applied, then clock the DUT.
  task automatic tick();
    bit          rdy;
    logic [15:0] h;
    rdy = (fifo_m.size() < 4);
    if (!act_m) begin
      if (fifo_m.size() > 0) begin
        h = fifo_m.pop_front();
        if (!(SKIP && h == 16'h0000)) begin
          spike_m = h;
          ein_m   = ein_sh_m;
          for (int i = 0; i < 16; i++) weight_m[i*4 +: 4] = w_sh_m[i];
          act_m   = 1'b1;
        end
      end
    end else if (ifc.flush_weight) begin
      act_m = 1'b0;
      fc_m  = fc_m + 8'd1;
    end
    if (cfg_w_we)   w_sh_m[cfg_w_addr] = cfg_w_data;
    if (cfg_ein_we) ein_sh_m = cfg_ein;
    if (ifc.frame_valid && rdy) fifo_m.push_back(ifc.frame_data);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [106:0] a, e;
    do_reset();
    tests++;
    a = act_vec(); e = exp_vec();
    if (a !== e) begin fails++; $display("FAIL reset_state: got %h exp %h", a, e); end
    ifc.frame_valid = 1'b1; ifc.frame_data = 16'h1234;
    tick();
    ifc.frame_valid = 1'b0;
    tick();
    ifc.flush_weight = 1'b1;
    tick();
    ifc.flush_weight = 1'b0;
    ifc.frame_valid = 1'b1; ifc.frame_data = 16'h4321;
    tick();
    ifc.frame_valid = 1'b0;
    tick();
    tests++;
    if (!(ifc.write === 1'b1 && frame_count === 8'd1)) begin
      fails++; $display("FAIL reset_setup: write=%b fc=%0d exp write=1 fc=1", ifc.write, frame_count);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (!(ifc.write === 1'b0 && ifc.frame_ready === 1'b1 && ifc.parallel_Ein === 16'hFFFF
          && frame_count === 8'd0 && busy === 1'b0)) begin
      fails++;
      $display("FAIL async_reset: write=%b ready=%b ein=%h fc=%0d busy=%b exp 0 1 ffff 0 0",
               ifc.write, ifc.frame_ready, ifc.parallel_Ein, frame_count, busy);
    end
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();
    tests++;
    a = act_vec(); e = exp_vec();
    if (a !== e) begin fails++; $display("FAIL reset_drops_frame: got %h exp %h", a, e); end
  endtask

  task automatic test_single_frame();
    logic [106:0] a, e;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      cfg_w_we = 1'b1; cfg_w_addr = 4'(i); cfg_w_data = 4'(i);
      tick();
    end
    cfg_w_we = 1'b0;
    ifc.frame_valid = 1'b1; ifc.frame_data = 16'hAAAA;
    tick();
    ifc.frame_valid = 1'b0;
    tests++;
    if (ifc.write !== 1'b0) begin fails++; $display("FAIL single_latency1: write=%b exp 0", ifc.write); end
    tick();
    tests++;
    if (!(ifc.write === 1'b1 && ifc.parallel_spike_in === 16'hAAAA
          && ifc.parallel_weight === 64'hFEDC_BA98_7654_3210)) begin
      fails++;
      $display("FAIL single_present: write=%b spike=%h w=%h exp 1 aaaa fedcba9876543210",
               ifc.write, ifc.parallel_spike_in, ifc.parallel_weight);
    end
    tick();
    tests++;
    a = act_vec(); e = exp_vec();
    if (a !== e) begin fails++; $display("FAIL single_hold: got %h exp %h", a, e); end
    ifc.flush_weight = 1'b1;
    tick();
    ifc.flush_weight = 1'b0;
    tests++;
    if (!(ifc.write === 1'b0 && frame_count === 8'd1 && ifc.parallel_spike_in === 16'hAAAA)) begin
      fails++;
      $display("FAIL single_flush: write=%b fc=%0d spike=%h exp 0 1 aaaa",
               ifc.write, frame_count, ifc.parallel_spike_in);
    end
  endtask

  task automatic test_fill();
    logic [15:0] d [6];
    logic [15:0] seen[$];
    logic [106:0] a, e;
    bit prev_w;
    do_reset();
    for (int i = 0; i < 6; i++) d[i] = 16'($urandom_range(1, 16'hFFFF));
    for (int i = 0; i < 6; i++) begin
      ifc.frame_valid = 1'b1; ifc.frame_data = d[i];
      tick();
      tests++;
      a = act_vec(); e = exp_vec();
      if (a !== e) begin fails++; $display("FAIL fill_push%0d: got %h exp %h", i, a, e); end
    end
    ifc.frame_valid = 1'b0;
    tests++;
    if (ifc.frame_ready !== 1'b0) begin fails++; $display("FAIL fill_full: ready=%b exp 0", ifc.frame_ready); end
    prev_w = 1'b1;
    seen.push_back(ifc.parallel_spike_in);
    for (int c = 0; c < 16; c++) begin
      ifc.flush_weight = act_m;
      tick();
      if (ifc.write === 1'b1 && !prev_w) seen.push_back(ifc.parallel_spike_in);
      prev_w = ifc.write;
      tests++;
      a = act_vec(); e = exp_vec();
      if (a !== e) begin fails++; $display("FAIL fill_drain%0d: got %h exp %h", c, a, e); end
    end
    ifc.flush_weight = 1'b0;
    tests++;
    if (seen.size() != 5) begin fails++; $display("FAIL fill_count: got %0d exp 5", seen.size()); end
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      tests++;
      if (seen[i] !== d[i]) begin fails++; $display("FAIL fill_order%0d: got %h exp %h", i, seen[i], d[i]); end
    end
  endtask

  task automatic test_shadow();
    do_reset();
    ifc.frame_valid = 1'b1; ifc.frame_data = 16'h0F0F;
    tick();
    ifc.frame_valid = 1'b0;
    tick();
    cfg_ein_we = 1'b1; cfg_ein = 16'h00FF;
    tick();
    cfg_ein_we = 1'b0;
    tests++;
    if (ifc.parallel_Ein !== 16'hFFFF) begin fails++; $display("FAIL shadow_frozen: ein=%h exp ffff", ifc.parallel_Ein); end
    ifc.flush_weight = 1'b1;
    tick();
    ifc.flush_weight = 1'b0;
    ifc.frame_valid = 1'b1; ifc.frame_data = 16'hF0F0;
    tick();
    ifc.frame_valid = 1'b0;
    tick();
    tests++;
    if (!(ifc.write === 1'b1 && ifc.parallel_Ein === 16'h00FF && ifc.parallel_spike_in === 16'hF0F0)) begin
      fails++;
      $display("FAIL shadow_applied: write=%b ein=%h spike=%h exp 1 00ff f0f0",
               ifc.write, ifc.parallel_Ein, ifc.parallel_spike_in);
    end
  endtask

  task automatic test_wrap();
    logic [106:0] a, e;
    int bad;
    do_reset();
    bad = 0;
    for (int f = 0; f < 256; f++) begin
      ifc.frame_valid = 1'b1; ifc.frame_data = 16'($urandom_range(1, 16'hFFFF));
      tick();
      ifc.frame_valid = 1'b0;
      tick();
      ifc.flush_weight = 1'b1;
      tick();
      ifc.flush_weight = 1'b0;
      a = act_vec(); e = exp_vec();
      if (a !== e) bad++;
      if (f == 254) begin
        tests++;
        if (frame_count !== 8'd255) begin fails++; $display("FAIL wrap_255: fc=%0d exp 255", frame_count); end
      end
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL wrap_steps: %0d bad cycles exp 0", bad); end
    tests++;
    if (frame_count !== 8'd0) begin fails++; $display("FAIL wrap_zero: fc=%0d exp 0", frame_count); end
  endtask

  task automatic test_empty_frame();
    logic [106:0] a, e;
    logic [7:0] exp_fc;
    int presented;
    do_reset();
    presented = 0;
    ifc.frame_valid = 1'b1; ifc.frame_data = 16'h0000;
    tick();
    ifc.frame_data = 16'hD55D;
    tick();
    ifc.frame_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      ifc.flush_weight = ifc.write;
      if (ifc.write === 1'b1) presented++;
      tick();
      tests++;
      a = act_vec(); e = exp_vec();
      if (a !== e) begin fails++; $display("FAIL empty_step%0d: got %h exp %h", c, a, e); end
    end
    ifc.flush_weight = 1'b0;
    exp_fc = SKIP ? 8'd1 : 8'd2;
    tests++;
    if (frame_count !== exp_fc || presented != int'(exp_fc)) begin
      fails++;
      $display("FAIL empty_count: fc=%0d presented=%0d exp %0d", frame_count, presented, exp_fc);
    end
    tests++;
    if (ifc.parallel_spike_in !== 16'hD55D) begin
      fails++; $display("FAIL empty_last: spike=%h exp d55d", ifc.parallel_spike_in);
    end
  endtask

  task automatic test_random();
    logic [106:0] a, e;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      ifc.frame_valid  = ($urandom_range(0, 1) == 1);
      ifc.frame_data   = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom());
      ifc.flush_weight = ($urandom_range(0, 3) == 0);
      cfg_w_we   = ($urandom_range(0, 2) == 0);
      cfg_w_addr = 4'($urandom_range(0, 15));
      cfg_w_data = 4'($urandom_range(0, 15));
      cfg_ein_we = ($urandom_range(0, 6) == 0);
      cfg_ein    = 16'($urandom());
      tick();
      tests++;
      a = act_vec(); e = exp_vec();
      if (a !== e) begin fails++; $display("FAIL random%0d: got %h exp %h", c, a, e); end
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_frame();
    test_fill();
    test_shadow();
    test_wrap();
    test_empty_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
